rs_rob_mc: RTL

RS_ROB_MC -- requirements
Module: rob_mc

---
 rtl/rs_rob_mc.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/rs_rob_mc.sv
// rs_rob_mc: reorder buffer with multi-port CDB writeback and multi-lane in-order commit.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   flush_i                    synchronous clear of every entry
//   alloc_*                    issue-side allocation handshake; alloc_rob_o is the granted tag
//   cdb_*                      CDB_SIZE writeback ports (result, resolved next PC)
//   src{1,2}_rob_i/_ready_o/_v_o  operand lookup with same-cycle CDB bypass
//   commit_en_i, commit_*      COMMIT_WIDTH retirement lanes (combinational)
//   redirect_valid_o/_pc_o     mispredicted branch on a retiring lane
//   rob_count_o, rob_empty_o   occupancy
module rs_rob_mc #(
  parameter int unsigned ROB_DEPTH    = 4,
  parameter int unsigned CDB_SIZE     = 3,
  parameter int unsigned COMMIT_WIDTH = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic                                   alloc_valid_i,
  output logic                                   alloc_ready_o,
  input  logic [4:0]                             alloc_rd_s_i,
  input  logic                                   alloc_is_branch_i,
  input  logic [31:0]                            alloc_pc_i,
  input  logic [31:0]                            alloc_pred_pc_i,
  output logic [ROB_DEPTH-1:0]                   alloc_rob_o,
  input  logic [CDB_SIZE-1:0]                    cdb_valid_i,
  input  logic [CDB_SIZE-1:0][ROB_DEPTH-1:0]     cdb_rob_i,
  input  logic [CDB_SIZE-1:0][31:0]              cdb_rd_v_i,
  input  logic [CDB_SIZE-1:0][31:0]              cdb_next_pc_i,
  input  logic [ROB_DEPTH-1:0]                   src1_rob_i,
  input  logic [ROB_DEPTH-1:0]                   src2_rob_i,
  output logic                                   src1_ready_o,
  output logic                                   src2_ready_o,
  output logic [31:0]                            src1_v_o,
  output logic [31:0]                            src2_v_o,
  input  logic                                   commit_en_i,
  output logic [COMMIT_WIDTH-1:0]                commit_valid_o,
  output logic [COMMIT_WIDTH-1:0][4:0]           commit_rd_s_o,
  output logic [COMMIT_WIDTH-1:0][31:0]          commit_rd_v_o,
  output logic [COMMIT_WIDTH-1:0][ROB_DEPTH-1:0] commit_rob_o,
  output logic [COMMIT_WIDTH-1:0][31:0]          commit_pc_o,
  output logic                                   redirect_valid_o,
  output logic [31:0]                            redirect_pc_o,
  output logic [ROB_DEPTH:0]                     rob_count_o,
  output logic                                   rob_empty_o
);

  localparam int unsigned N = 2 ** ROB_DEPTH;

  typedef logic [ROB_DEPTH-1:0] tag_t;
  typedef logic [ROB_DEPTH:0]   cnt_t;

  logic [N-1:0]       valid_q, valid_d, ready_q, ready_d;
  logic [N-1:0]       is_br_q, is_br_d, mispred_q, mispred_d;
  logic [N-1:0][4:0]  rd_s_q, rd_s_d;
  logic [N-1:0][31:0] rd_v_q, rd_v_d, pc_q, pc_d, next_pc_q, next_pc_d;
  tag_t               alloc_ptr_q, alloc_ptr_d, commit_ptr_q, commit_ptr_d;
  cnt_t               count_q, count_d;

  tag_t [COMMIT_WIDTH-1:0] lane_idx;
  logic [COMMIT_WIDTH-1:0] lane_valid;
  cnt_t                    n_retire;
  logic                    redirect;
  logic [31:0]             redirect_pc;
  logic                    alloc_fire;

  // Commit lanes: a contiguous run of registered-ready entries from the head, cut after the
  // first mispredicted one (that lane still retires and raises the redirect).
  always_comb begin
    logic go;
    go          = 1'b1;
    lane_idx    = '0;
    lane_valid  = '0;
    n_retire    = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      lane_idx[k] = commit_ptr_q + tag_t'(k);
      if (go && (count_q > cnt_t'(k)) && valid_q[lane_idx[k]] && ready_q[lane_idx[k]]) begin
        lane_valid[k] = 1'b1;
        n_retire      = n_retire + cnt_t'(1);
        if (mispred_q[lane_idx[k]]) begin
          redirect    = 1'b1;
          redirect_pc = next_pc_q[lane_idx[k]];
          go          = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      commit_rd_s_o[k] = rd_s_q[lane_idx[k]];
      commit_rd_v_o[k] = rd_v_q[lane_idx[k]];
      commit_pc_o[k]   = pc_q[lane_idx[k]];
    end
  end

  assign commit_valid_o   = lane_valid;
  assign commit_rob_o     = lane_idx;
  assign redirect_valid_o = redirect;
  assign redirect_pc_o    = redirect_pc;
  assign alloc_ready_o    = (count_q < cnt_t'(N)) && !redirect;
  assign alloc_rob_o      = alloc_ptr_q;
  assign alloc_fire       = alloc_valid_i && alloc_ready_o;
  assign rob_count_o      = count_q;
  assign rob_empty_o      = (count_q == '0);

  // Operand lookup; later CDB ports overwrite earlier ones so the highest index wins.
  tag_t [1:0]        src_tag;
  logic [1:0]        src_rdy;
  logic [1:0][31:0]  src_val;

  assign src_tag = {src2_rob_i, src1_rob_i};

  always_comb begin
    src_rdy = '0;
    src_val = '0;
    for (int s = 0; s < 2; s++) begin
      if (valid_q[src_tag[s]]) begin
        if (ready_q[src_tag[s]]) begin
          src_rdy[s] = 1'b1;
          src_val[s] = rd_v_q[src_tag[s]];
        end
        for (int i = 0; i < CDB_SIZE; i++) begin
          if (cdb_valid_i[i] && (cdb_rob_i[i] == src_tag[s])) begin
            src_rdy[s] = 1'b1;
            src_val[s] = cdb_rd_v_i[i];
          end
        end
      end
    end
  end

  assign src1_ready_o = src_rdy[0];
  assign src2_ready_o = src_rdy[1];
  assign src1_v_o     = src_val[0];
  assign src2_v_o     = src_val[1];

  always_comb begin
    tag_t t;
    valid_d      = valid_q;
    ready_d      = ready_q;
    is_br_d      = is_br_q;
    mispred_d    = mispred_q;
    rd_s_d       = rd_s_q;
    rd_v_d       = rd_v_q;
    pc_d         = pc_q;
    next_pc_d    = next_pc_q;
    alloc_ptr_d  = alloc_ptr_q;
    commit_ptr_d = commit_ptr_q;
    count_d      = count_q;
    t            = '0;
    if (flush_i || (commit_en_i && redirect)) begin
      valid_d      = '0;
      ready_d      = '0;
      mispred_d    = '0;
      alloc_ptr_d  = '0;
      commit_ptr_d = '0;
      count_d      = '0;
    end else begin
      if (alloc_fire) begin
        valid_d[alloc_ptr_q]   = 1'b1;
        ready_d[alloc_ptr_q]   = 1'b0;
        mispred_d[alloc_ptr_q] = 1'b0;
        is_br_d[alloc_ptr_q]   = alloc_is_branch_i;
        rd_s_d[alloc_ptr_q]    = alloc_rd_s_i;
        pc_d[alloc_ptr_q]      = alloc_pc_i;
        next_pc_d[alloc_ptr_q] = alloc_pred_pc_i;
        alloc_ptr_d            = alloc_ptr_q + tag_t'(1);
      end
      // Mispredict is judged against the prediction held before this cycle's writes.
      for (int i = 0; i < CDB_SIZE; i++) begin
        t = cdb_rob_i[i];
        if (cdb_valid_i[i] && valid_q[t]) begin
          ready_d[t] = 1'b1;
          rd_v_d[t]  = cdb_rd_v_i[i];
          if (is_br_q[t]) begin
            mispred_d[t] = (cdb_next_pc_i[i] != next_pc_q[t]);
            next_pc_d[t] = cdb_next_pc_i[i];
          end
        end
      end
      if (commit_en_i) begin
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
          if (lane_valid[k]) begin
            valid_d[lane_idx[k]]   = 1'b0;
            ready_d[lane_idx[k]]   = 1'b0;
            mispred_d[lane_idx[k]] = 1'b0;
          end
        end
        commit_ptr_d = commit_ptr_q + tag_t'(n_retire);
      end
      count_d = count_q + cnt_t'(alloc_fire) - (commit_en_i ? n_retire : '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= '0;
      ready_q      <= '0;
      is_br_q      <= '0;
      mispred_q    <= '0;
      rd_s_q       <= '0;
      rd_v_q       <= '0;
      pc_q         <= '0;
      next_pc_q    <= '0;
      alloc_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
    end else begin
      valid_q      <= valid_d;
      ready_q      <= ready_d;
      is_br_q      <= is_br_d;
      mispred_q    <= mispred_d;
      rd_s_q       <= rd_s_d;
      rd_v_q       <= rd_v_d;
      pc_q         <= pc_d;
      next_pc_q    <= next_pc_d;
      alloc_ptr_q  <= alloc_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      count_q      <= count_d;
    end
  end

endmodule
